// File: rtl/shared_memory_arbiter.sv
// Unified byte-enabled RAM shared by NUM_PORTS requestors: round-robin arbitration,
// valid/ready request handshake and a fixed READ_LATENCY response pulse to the owner.
module shared_memory_arbiter #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEMORY_SIZE  = 4096,
  parameter string       MEMORY_FILE  = "",
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_write_data,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_byte_enable,
  output logic [NUM_PORTS-1:0]                req_ready,
  output logic [NUM_PORTS-1:0]                resp_valid,
  output logic [DATA_WIDTH-1:0]               resp_read_data,
  output logic                                resp_error
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned Words = MEMORY_SIZE / Bytes;
  localparam int unsigned LsbW  = $clog2(Bytes);
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned PtrW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] MemLimit = (ADDR_WIDTH+1)'(MEMORY_SIZE);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]        rr_q;
  logic [PtrW-1:0]        owner_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q;

  logic [DATA_WIDTH-1:0]  mem [Words];

  logic                   grant_found;
  logic [PtrW-1:0]        grant_idx;
  logic                   resp_cycle;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_write;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [Bytes-1:0]       sel_be;
  logic                   in_range;
  logic [IdxW-1:0]        word_idx;

  // Round-robin scan starting at rr_q; first valid port wins.
  always_comb begin
    int unsigned scan;
    scan        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      scan = (32'(rr_q) + k) % NUM_PORTS;
      if (!grant_found && req_valid[PtrW'(scan)]) begin
        grant_found = 1'b1;
        grant_idx   = PtrW'(scan);
      end
    end
  end

  always_comb begin
    sel_addr  = req_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_write = req_write[grant_idx];
    sel_wdata = req_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_be    = req_byte_enable[grant_idx*Bytes +: Bytes];
    in_range  = ({1'b0, sel_addr} < MemLimit);
    word_idx  = sel_addr[LsbW +: IdxW];
  end

  // The response cycle doubles as an idle cycle so back-to-back accepts are possible.
  always_comb begin
    resp_cycle = (state_q == StBusy) && (cnt_q == '0);
    accept     = reset && grant_found && ((state_q == StIdle) || resp_cycle);
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (accept) begin
      state_d = StBusy;
      cnt_d   = CntW'(READ_LATENCY - 1);
    end else if (resp_cycle) begin
      state_d = StIdle;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    req_ready      = accept ? (NUM_PORTS'(1) << grant_idx) : '0;
    resp_valid     = resp_cycle ? (NUM_PORTS'(1) << owner_q) : '0;
    resp_read_data = resp_cycle ? rdata_q : '0;
    resp_error     = resp_cycle && err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rr_q    <= '0;
      owner_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        owner_q <= grant_idx;
        rr_q    <= PtrW'((32'(grant_idx) + 32'd1) % NUM_PORTS);
        rdata_q <= (!sel_write && in_range) ? mem[word_idx] : '0;
        err_q   <= !in_range;
      end
    end
  end

  // RAM is never cleared; a write commits on its accept edge.
  always_ff @(posedge clk) begin
    if (accept && sel_write && in_range) begin
      for (int unsigned b = 0; b < Bytes; b++) begin
        if (sel_be[b]) mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Bench for shared_memory_arbiter: two instances (2 ports/latency 1, 3 ports/latency 3)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_shared_memory_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic [2:0]  v     [2];
  logic [2:0]  w     [2];
  logic [95:0] addr  [2];
  logic [95:0] wdat  [2];
  logic [11:0] be    [2];
  logic [2:0]  rdy   [2];
  logic [2:0]  rv    [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [1:0] rdy_a, rv_a;
  logic [2:0] rdy_b, rv_b;
  assign rdy[0] = {1'b0, rdy_a};
  assign rv[0]  = {1'b0, rv_a};
  assign rdy[1] = rdy_b;
  assign rv[1]  = rv_b;

  shared_memory_arbiter #(
    .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEMORY_SIZE(4096),
    .MEMORY_FILE(""), .READ_LATENCY(1)
  ) u_dut_a (
    .clk(clk), .reset(rst[0]), .req_valid(v[0][1:0]), .req_write(w[0][1:0]),
    .req_address(addr[0][63:0]), .req_write_data(wdat[0][63:0]),
    .req_byte_enable(be[0][7:0]), .req_ready(rdy_a), .resp_valid(rv_a),
    .resp_read_data(rdata[0]), .resp_error(err[0])
  );

  shared_memory_arbiter #(
    .NUM_PORTS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEMORY_SIZE(4096),
    .MEMORY_FILE(""), .READ_LATENCY(3)
  ) u_dut_b (
    .clk(clk), .reset(rst[1]), .req_valid(v[1]), .req_write(w[1]),
    .req_address(addr[1]), .req_write_data(wdat[1]),
    .req_byte_enable(be[1]), .req_ready(rdy_b), .resp_valid(rv_b),
    .resp_read_data(rdata[1]), .resp_error(err[1])
  );

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: no DUT event within bound at %0t", name, $time);
  endtask

  // Transaction-level model: one outstanding response with a due cycle number.
  function automatic int np_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  int unsigned mcyc  [2];
  bit          pend  [2];
  int unsigned pdue  [2];
  int          pport [2];
  logic [31:0] pdata [2];
  bit          perr  [2];
  int          rr    [2];
  logic [31:0] mmem  [2][1024];

  function automatic int arb(input logic [2:0] vv, input int ptr, input int np);
    for (int k = 0; k < np; k++) begin
      if (vv[(ptr + k) % np]) return (ptr + k) % np;
    end
    return -1;
  endfunction

  function automatic bit free_now(input int d);
    return !pend[d] || (pdue[d] == mcyc[d]);
  endfunction

  task automatic model_step();
    int g;
    logic [31:0] a;
    logic [31:0] data;
    bit inr;
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        pend[d] = 1'b0;
        rr[d]   = 0;
      end else begin
        g = arb(v[d], rr[d], np_of(d));
        if (free_now(d) && g >= 0) begin
          a    = addr[d][g*32 +: 32];
          inr  = (a < 32'd4096);
          data = (!w[d][g] && inr) ? mmem[d][a[11:2]] : 32'h0;
          if (w[d][g] && inr) begin
            for (int b = 0; b < 4; b++) begin
              if (be[d][g*4 + b]) mmem[d][a[11:2]][b*8 +: 8] = wdat[d][g*32 + b*8 +: 8];
            end
          end
          pend[d]  = 1'b1;
          pdue[d]  = mcyc[d] + lat_of(d);
          pport[d] = g;
          pdata[d] = data;
          perr[d]  = !inr;
          rr[d]    = (g + 1) % np_of(d);
        end else if (pend[d] && pdue[d] == mcyc[d]) begin
          pend[d] = 1'b0;
        end
      end
      mcyc[d]++;
    end
  endtask

  task automatic compare_all();
    int g;
    logic [2:0]  er, ev;
    logic [31:0] ed;
    logic        ee;
    for (int d = 0; d < 2; d++) begin
      er = '0; ev = '0; ed = '0; ee = 1'b0;
      if (rst[d]) begin
        g = arb(v[d], rr[d], np_of(d));
        if (free_now(d) && g >= 0) er = 3'(1) << g;
        if (pend[d] && pdue[d] == mcyc[d]) begin
          ev = 3'(1) << pport[d];
          ed = pdata[d];
          ee = perr[d];
        end
      end
      check($sformatf("req_ready[dut%0d]", d), 64'(rdy[d]), 64'(er));
      check($sformatf("resp_valid[dut%0d]", d), 64'(rv[d]), 64'(ev));
      check($sformatf("resp_read_data[dut%0d]", d), 64'(rdata[d]), 64'(ed));
      check($sformatf("resp_error[dut%0d]", d), 64'(err[d]), 64'(ee));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mcyc[d] = 0; pend[d] = 1'b0; pdue[d] = 0; pport[d] = 0;
      pdata[d] = '0; perr[d] = 1'b0; rr[d] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  // Driver helpers; all start and end at posedge + 1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input int p, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b);
    int n;
    n = 0;
    v[d][p] = 1'b1;
    w[d][p] = wr;
    addr[d][p*32 +: 32] = a;
    wdat[d][p*32 +: 32] = wd;
    be[d][p*4 +: 4] = b;
    @(negedge clk);
    while (!rdy[d][p] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d][p]) timeout($sformatf("accept dut%0d port%0d", d, p));
    step();
    v[d][p] = 1'b0;
  endtask

  task automatic wait_resp(input int d, input int p, output logic [31:0] data,
                           output logic e, output int lat);
    lat = 0;
    data = '0;
    e = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv[d][p] && lat < 20);
    if (!rv[d][p]) timeout($sformatf("response dut%0d port%0d", d, p));
    data = rdata[d];
    e = err[d];
    step();
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0000_1000 | 32'($urandom_range(0, 255));
    if (r == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    if (r == 2) return 32'($urandom_range(0, 3));
    return 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
  endfunction

  logic [31:0] d_rd;
  logic        d_err;
  int          d_lat;
  logic [2:0]  acc [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; v[d] = '0; w[d] = '0; addr[d] = '0; wdat[d] = '0; be[d] = '0;
    end
    #2;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Requests held through reset; port 0 must win on release.
    v[0] = 3'b011; w[0] = 3'b011;
    v[1] = 3'b111; w[1] = 3'b111;
    addr[0] = {32'h0, 32'h104, 32'h100};
    addr[1] = {32'h108, 32'h104, 32'h100};
    wdat[0] = {3{32'h5555_AAAA}};
    wdat[1] = {3{32'h1234_5678}};
    be[0] = 12'hFFF;
    be[1] = 12'hFFF;
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ready dut%0d", d), 64'(rdy[d]), 64'h0);
      check($sformatf("reset valid dut%0d", d), 64'(rv[d]), 64'h0);
      check($sformatf("reset data dut%0d", d), 64'(rdata[d]), 64'h0);
      check($sformatf("reset error dut%0d", d), 64'(err[d]), 64'h0);
    end
    step();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);
    check("first grant dut0", 64'(rdy[0]), 64'h1);
    check("first grant dut1", 64'(rdy[1]), 64'h1);
    step();
    v[0] = '0;
    v[1] = '0;
    repeat (5) step();

    // Initialise every word the rest of the run can read.
    for (int d = 0; d < 2; d++) begin
      issue(d, 0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF);
      for (int i = 0; i < 16; i++) issue(d, 0, 1'b1, 32'h100 + 32'(i) * 4, $urandom, 4'hF);
    end
    repeat (5) step();

    // Write on port 1, read back on port 0.
    issue(0, 1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    wait_resp(0, 1, d_rd, d_err, d_lat);
    check("write resp data", 64'(d_rd), 64'h0);
    issue(0, 0, 1'b0, 32'h100, 32'h0, 4'h0);
    wait_resp(0, 0, d_rd, d_err, d_lat);
    check("raw data", 64'(d_rd), 64'hDEAD_BEEF);
    check("raw latency", 64'(d_lat), 64'd1);

    // Byte lanes.
    issue(0, 0, 1'b1, 32'h104, 32'h1122_3344, 4'hF);
    wait_resp(0, 0, d_rd, d_err, d_lat);
    issue(0, 0, 1'b1, 32'h104, 32'hAABB_CCDD, 4'b0101);
    wait_resp(0, 0, d_rd, d_err, d_lat);
    issue(0, 0, 1'b0, 32'h107, 32'h0, 4'h0);
    wait_resp(0, 0, d_rd, d_err, d_lat);
    check("byte lanes", 64'(d_rd), 64'h11BB_33DD);

    // Out of range: error on read, write must not alias onto word 0.
    issue(0, 0, 1'b0, 32'h1000, 32'h0, 4'h0);
    wait_resp(0, 0, d_rd, d_err, d_lat);
    check("oor read error", 64'(d_err), 64'h1);
    check("oor read data", 64'(d_rd), 64'h0);
    issue(0, 1, 1'b1, 32'h1000, 32'h1234_5678, 4'hF);
    wait_resp(0, 1, d_rd, d_err, d_lat);
    check("oor write error", 64'(d_err), 64'h1);
    issue(0, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_resp(0, 0, d_rd, d_err, d_lat);
    check("oor write ignored", 64'(d_rd), 64'h0BAD_F00D);
    check("in-range error", 64'(d_err), 64'h0);

    // Both ports continuously valid: strict alternation starting at port 0.
    issue(0, 1, 1'b0, 32'h108, 32'h0, 4'h0);
    v[0] = 3'b011; w[0] = 3'b000;
    addr[0] = {32'h0, 32'h110, 32'h10C};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("alternate grant %0d", k), 64'(rdy[0]), (k % 2 == 0) ? 64'h1 : 64'h2);
      step();
    end
    v[0] = '0;
    repeat (3) step();

    // Reset during an outstanding write on the 3-port instance.
    issue(1, 1, 1'b1, 32'h104, 32'hCAFE_F00D, 4'hF);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("dropped resp %0d", k), 64'(rv[1]), 64'h0);
      step();
      if (k == 0) rst[1] = 1'b0;
      if (k == 1) rst[1] = 1'b1;
    end
    v[1] = 3'b111; w[1] = 3'b000;
    addr[1] = {32'h10C, 32'h108, 32'h104};
    @(negedge clk);
    check("rr after reset", 64'(rdy[1]), 64'h1);
    step();
    v[1] = '0;
    wait_resp(1, 0, d_rd, d_err, d_lat);
    check("latency 3", 64'(d_lat), 64'd3);
    check("write survives reset", 64'(d_rd), 64'hCAFE_F00D);
    repeat (3) step();

    // Randomised traffic on both instances, honouring hold-until-ready.
    acc[0] = '0;
    acc[1] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < np_of(d); p++) begin
          if (!(v[d][p] && !acc[d][p] && $urandom_range(0, 9) != 0)) begin
            v[d][p] = ($urandom_range(0, 2) != 0);
            w[d][p] = $urandom_range(0, 1);
            addr[d][p*32 +: 32] = rnd_addr();
            wdat[d][p*32 +: 32] = $urandom;
            be[d][p*4 +: 4] = 4'($urandom_range(0, 15));
          end
        end
      end
      @(negedge clk);
      acc[0] = rdy[0];
      acc[1] = rdy[1];
      step();
    end
    v[0] = '0;
    v[1] = '0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
